// File: rtl/apb_pkg.sv
// apb_pkg: shared APB widths and the requester state encoding.
package apb_pkg;
    localparam int APB_ADDR_W = 10;
    localparam int APB_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_master_state_e;
endpackage

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with wait-state watchdog.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_timeout_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              pwrite_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_master_state_e r_state, w_next;
    logic [CNT_W-1:0]  r_wait;
    logic              w_access, w_accept, w_timeout, w_done;
    logic              r_rsp_valid, r_rsp_timeout, r_pwrite;
    logic [DATA_W-1:0] r_rsp_rdata, r_pwdata;
    logic [ADDR_W-1:0] r_paddr;

    // A ready completer on the last watchdog cycle still completes normally.
    always_comb begin
        w_access  = r_state == ACCESS;
        w_accept  = cmd_valid_i && r_state == IDLE;
        w_timeout = w_access && !pready_i && r_wait == CNT_LAST;
        w_done    = w_access && (pready_i || w_timeout);
        w_next    = r_state == IDLE  ? (cmd_valid_i ? SETUP : IDLE) :
                    r_state == SETUP ? ACCESS :
                    (w_access && !w_done) ? ACCESS : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_wait        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
        end else begin
            r_state       <= w_next;
            r_rsp_valid   <= w_done;
            r_rsp_timeout <= w_timeout;
            r_rsp_rdata   <= (w_access && pready_i && !r_pwrite) ? prdata_i : '0;
            if (r_state == SETUP)
                r_wait <= '0;
            else if (w_access && !pready_i && r_wait != CNT_LAST)
                r_wait <= r_wait + CNT_W'(1);
            if (w_accept) begin
                r_paddr  <= cmd_addr_i;
                r_pwrite <= cmd_write_i;
                r_pwdata <= cmd_wdata_i;
            end
        end
    end

    assign cmd_ready_o   = r_state == IDLE;
    assign psel_o        = r_state == SETUP || r_state == ACCESS;
    assign penable_o     = w_access;
    assign paddr_o       = r_paddr;
    assign pwrite_o      = r_pwrite;
    assign pwdata_o      = r_pwdata;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_timeout_o = r_rsp_timeout;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: vector table, corner sequences and random traffic against a memory-model reference.
module tb_apb_master;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid_i = 1'b0, cmd_write_i = 1'b0, pready_i = 1'b0;
    logic [9:0]  cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0, prdata_i = '0;
    logic        cmd_ready_o, rsp_valid_o, rsp_timeout_o, psel_o, penable_o, pwrite_o;
    logic [31:0] rsp_rdata_o, pwdata_o;
    logic [9:0]  paddr_o;

    int total = 0;
    int bad = 0;
    logic [31:0] slv_mem [1024];
    logic [31:0] ref_mem [1024];

    typedef struct {
        bit          w;
        logic [9:0]  a;
        logic [31:0] d;
        int          waits;
        bit          setup_rdy;
        int          exp_lat;
        logic [31:0] exp_rd;
        bit          exp_to;
    } vec_t;
    vec_t vecs [9];

    apb_master #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_timeout_o(rsp_timeout_o),
        .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a transfer stalled for TIMEOUT or more ACCESS cycles aborts and leaves memory untouched.
    task automatic model(input vec_t v, output int lat, output logic [31:0] rd, output bit to);
        to  = v.waits >= TIMEOUT;
        lat = to ? TIMEOUT + 2 : 3 + v.waits;
        rd  = (!v.w && !to) ? ref_mem[v.a] : 32'h0;
        if (v.w && !to) ref_mem[v.a] = v.d;
    endtask

    // Entered just after a negedge with the DUT idle; returns cycles from accept edge to response.
    task automatic xfer(input vec_t v, output int lat, output logic [31:0] rd, output bit to);
        int k = 0;
        bit done = 0;
        lat = -1; rd = '0; to = 0;
        chk("ready_idle", 64'(cmd_ready_o), 64'(1'b1));
        cmd_valid_i = 1'b1; cmd_write_i = v.w; cmd_addr_i = v.a; cmd_wdata_i = v.d;
        @(negedge clk);
        cmd_valid_i = 1'b0; cmd_write_i = 1'($urandom); cmd_addr_i = 10'($urandom); cmd_wdata_i = $urandom;
        chk("setup_phase", 64'({psel_o, penable_o, cmd_ready_o}), 64'(3'b100));
        chk("setup_addr", 64'(paddr_o), 64'(v.a));
        pready_i = v.setup_rdy; prdata_i = $urandom;
        for (int c = 2; c < 64 && !done; c++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                lat = c; rd = rsp_rdata_o; to = rsp_timeout_o; done = 1;
                chk("rsp_idle", 64'({psel_o, penable_o, cmd_ready_o}), 64'(3'b001));
                pready_i = 1'b0;
            end else begin
                chk("access_phase", 64'({psel_o, penable_o}), 64'(2'b11));
                chk("access_ctl", 64'({pwrite_o, paddr_o}), 64'({v.w, v.a}));
                chk("access_wdata", 64'(pwdata_o), 64'(v.d));
                pready_i = k == v.waits;
                prdata_i = (pready_i && !v.w) ? slv_mem[v.a] : $urandom;
                if (pready_i && v.w) slv_mem[v.a] = v.d;
                k++;
            end
        end
        chk("rsp_seen", 64'(done), 64'(1'b1));
        pready_i = 1'b0;
        @(negedge clk);
        chk("rsp_single_pulse", 64'({rsp_valid_o, rsp_timeout_o, rsp_rdata_o}), 64'(0));
        chk("addr_hold", 64'({pwrite_o, paddr_o, pwdata_o}), {21'h0, v.w, v.a, v.d});
    endtask

    initial begin
        int lat, elat;
        logic [31:0] rd, erd;
        bit to, eto;
        vec_t v;
        for (int i = 0; i < 1024; i++) begin
            slv_mem[i] = '0;
            ref_mem[i] = '0;
        end
        vecs[0] = '{1'b1, 10'h003, 32'hDEADBEEF, 0,    1'b0, 3,  32'h0,        1'b0};
        vecs[1] = '{1'b0, 10'h003, 32'h0,        2,    1'b0, 5,  32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 10'h003, 32'h0,        1000, 1'b0, 18, 32'h0,        1'b1};
        vecs[3] = '{1'b0, 10'h003, 32'h0,        3,    1'b1, 6,  32'hDEADBEEF, 1'b0};
        vecs[4] = '{1'b1, 10'h3FF, 32'hA5A5A5A5, 15,   1'b0, 18, 32'h0,        1'b0};
        vecs[5] = '{1'b0, 10'h3FF, 32'h0,        0,    1'b1, 3,  32'hA5A5A5A5, 1'b0};
        vecs[6] = '{1'b1, 10'h003, 32'h11111111, 16,   1'b0, 18, 32'h0,        1'b1};
        vecs[7] = '{1'b0, 10'h003, 32'h0,        0,    1'b0, 3,  32'hDEADBEEF, 1'b0};
        vecs[8] = '{1'b0, 10'h000, 32'h0,        0,    1'b0, 3,  32'h0,        1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_timeout_o}), 64'(0));
        chk("reset_data", 64'({paddr_o, pwdata_o, rsp_rdata_o}) | 64'(|{paddr_o, pwdata_o, rsp_rdata_o}), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(cmd_ready_o), 64'(1'b1));

        foreach (vecs[i]) begin
            xfer(vecs[i], lat, rd, to);
            model(vecs[i], elat, erd, eto);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_timeout", i), 64'(to), 64'(vecs[i].exp_to));
        end

        // Back-to-back: write then read held on cmd_valid_i, one idle cycle between PSEL pulses.
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 10'h007; cmd_wdata_i = 32'h12345678;
        @(negedge clk);
        chk("b2b_setup1", 64'({psel_o, penable_o, pwrite_o}), 64'(3'b101));
        cmd_write_i = 1'b0; cmd_wdata_i = 32'h0; pready_i = 1'b1;
        @(negedge clk);
        chk("b2b_access1", 64'({psel_o, penable_o, cmd_ready_o}), 64'(3'b110));
        slv_mem[7] = 32'h12345678; ref_mem[7] = 32'h12345678;
        @(negedge clk);
        chk("b2b_rsp1", 64'({rsp_valid_o, rsp_timeout_o, rsp_rdata_o}), {30'h0, 2'b10, 32'h0});
        chk("b2b_idle_gap", 64'({psel_o, cmd_ready_o}), 64'(2'b01));
        pready_i = 1'b0;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        chk("b2b_setup2", 64'({psel_o, penable_o, pwrite_o, paddr_o}), 64'({3'b100, 10'h007}));
        @(negedge clk);
        chk("b2b_access2", 64'({psel_o, penable_o}), 64'(2'b11));
        pready_i = 1'b1; prdata_i = slv_mem[7];
        @(negedge clk);
        pready_i = 1'b0;
        chk("b2b_rsp2", 64'({rsp_valid_o, rsp_timeout_o, rsp_rdata_o}), {30'h0, 2'b10, 32'h12345678});
        @(negedge clk);

        // Reset during an ACCESS wait state drops the command.
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 10'h155; cmd_wdata_i = 32'hCAFEF00D;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_access", 64'({psel_o, penable_o}), 64'(2'b11));
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_ctl", 64'({psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_timeout_o}), 64'(0));
        chk("midreset_data", 64'({paddr_o, pwdata_o}), 64'(0));
        chk("midreset_rdata", 64'(rsp_rdata_o), 64'(0));
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", 64'({rsp_valid_o, psel_o, cmd_ready_o}), 64'(3'b001));
        end
        v = '{1'b0, 10'h007, 32'h0, 1, 1'b0, 0, 32'h0, 1'b0};
        xfer(v, lat, rd, to);
        model(v, elat, erd, eto);
        chk("post_reset_lat", 64'(lat), 64'(4));
        chk("post_reset_rdata", 64'(rd), 64'(32'h12345678));

        for (int n = 0; n < 60; n++) begin
            int sel = $urandom_range(0, 9);
            v.w = 1'($urandom);
            v.a = $urandom_range(0, 1) ? 10'($urandom_range(1016, 1023)) : 10'($urandom_range(0, 7));
            v.d = $urandom;
            v.waits = sel < 8 ? sel : $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
            v.setup_rdy = 1'($urandom);
            xfer(v, lat, rd, to);
            model(v, elat, erd, eto);
            chk($sformatf("rand%0d_latency", n), 64'(lat), 64'(elat));
            chk($sformatf("rand%0d_rdata", n), 64'(rd), 64'(erd));
            chk($sformatf("rand%0d_timeout", n), 64'(to), 64'(eto));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
